spi_xfer_arbiter: RTL and testbench

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_rr_arb2.sv | 29 ++
 rtl/spi_xfer_arbiter.sv | 116 +++++++++++
 tb/tb_spi_xfer_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer arbiter: FSM encoding, SPCR bit
// positions and the layout of the 24-bit requester payload.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        LOAD,
        XFER,
        DONE
    } state_t;

    localparam int SPE_BIT    = 6;
    localparam int SPCR_LSB   = 16;
    localparam int SPIBR_LSB  = 8;
    localparam int TXDATA_LSB = 0;

    function automatic logic [7:0] cfg_field(input logic [23:0] cfg, input int lsb);
        return cfg[lsb +: 8];
    endfunction

    function automatic logic [7:0] with_spe(input logic [7:0] spcr, input logic spe);
        logic [7:0] r;
        r          = spcr;
        r[SPE_BIT] = spe;
        return r;
    endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so a tie
// goes to the other requester.
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master core between two requesters: arbitrates, programs the
// core, runs one byte transfer with a timeout and returns the received byte.
module spi_xfer_arbiter #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int TMO_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] cfg0,
    input  logic [23:0] cfg1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  rx_data,
    output logic        err,
    output logic [7:0]  spcr_o,
    output logic [7:0]  spibr_o,
    output logic [7:0]  spdr_o,
    output logic        ss_master_o,
    input  logic        spif_i,
    input  logic [7:0]  spdr_i,
    output logic        busy
);

    import spi_pkg::*;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

    state_t           state;
    logic [23:0]      cfg_q;
    logic             owner;
    logic [TMO_W-1:0] cnt;
    logic [TMO_W-1:0] cnt_inc;
    logic [1:0]       gnt;
    logic [23:0]      sel_cfg;

    assign cnt_inc = cnt + 1'b1;
    assign sel_cfg = gnt[1] ? cfg1 : cfg0;

    spi_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .update (state == IDLE),
        .gnt    (gnt)
    );

    // cnt_inc includes the current XFER cycle, so a timeout exits after exactly
    // TIMEOUT_CYC XFER cycles and the counter never reaches its wrap point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cfg_q       <= '0;
            owner       <= 1'b0;
            cnt         <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rx_data     <= '0;
            err         <= 1'b0;
            spcr_o      <= '0;
            spibr_o     <= '0;
            spdr_o      <= '0;
            ss_master_o <= 1'b1;
            busy        <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        cfg_q       <= sel_cfg;
                        owner       <= gnt[1];
                        spcr_o      <= with_spe(cfg_field(sel_cfg, SPCR_LSB), 1'b0);
                        spibr_o     <= cfg_field(sel_cfg, SPIBR_LSB);
                        ss_master_o <= 1'b1;
                        busy        <= 1'b1;
                        state       <= CFG;
                    end
                end
                CFG: begin
                    spdr_o      <= cfg_field(cfg_q, TXDATA_LSB);
                    spcr_o      <= with_spe(cfg_field(cfg_q, SPCR_LSB), 1'b1);
                    ss_master_o <= 1'b0;
                    state       <= LOAD;
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= XFER;
                end
                XFER: begin
                    if (spif_i || (cnt_inc == TMO_LIM)) begin
                        rx_data     <= spdr_i;
                        err         <= !spif_i;
                        ack0        <= !owner;
                        ack1        <= owner;
                        ss_master_o <= 1'b1;
                        spcr_o      <= with_spe(spcr_o, 1'b0);
                        state       <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter; inputs change and outputs are sampled
// on the falling clock edge.
module tb_spi_xfer_arbiter;

    localparam int TMO = 12;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [23:0] cfg0, cfg1;
    logic        ack0, ack1;
    logic [7:0]  rx_data;
    logic        err;
    logic [7:0]  spcr_o, spibr_o, spdr_o;
    logic        ss_master_o;
    logic        spif_i;
    logic [7:0]  spdr_i;
    logic        busy;

    int total = 0;
    int bad   = 0;

    spi_xfer_arbiter #(.TIMEOUT_CYC(TMO), .TMO_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .cfg0        (cfg0),
        .cfg1        (cfg1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rx_data     (rx_data),
        .err         (err),
        .spcr_o      (spcr_o),
        .spibr_o     (spibr_o),
        .spdr_o      (spdr_o),
        .ss_master_o (ss_master_o),
        .spif_i      (spif_i),
        .spdr_i      (spdr_i),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"},  32'(ack0),        32'h0);
        check({tag, "_ack1"},  32'(ack1),        32'h0);
        check({tag, "_err"},   32'(err),         32'h0);
        check({tag, "_rx"},    32'(rx_data),     32'h0);
        check({tag, "_spcr"},  32'(spcr_o),      32'h0);
        check({tag, "_spibr"}, 32'(spibr_o),     32'h0);
        check({tag, "_spdr"},  32'(spdr_o),      32'h0);
        check({tag, "_ss"},    32'(ss_master_o), 32'h1);
        check({tag, "_busy"},  32'(busy),        32'h0);
    endtask

    initial begin : main
        int         waited;
        logic [1:0] exp_g;

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; cfg0 = '0; cfg1 = '0;
        spif_i = 1'b0; spdr_i = '0;
        tick(2);
        check_reset_outputs("por");
        rst = 1'b1;

        // Single transfer, spif on the 4th XFER cycle, latency 7
        cfg0 = 24'h52_03_A5; spdr_i = 8'h3C; req0 = 1'b1;
        tick();
        check("t1_cfg_busy",  32'(busy),        32'h1);
        check("t1_cfg_spcr",  32'(spcr_o),      32'h12);
        check("t1_cfg_spibr", 32'(spibr_o),     32'h03);
        check("t1_cfg_ss",    32'(ss_master_o), 32'h1);
        tick();
        check("t1_load_spdr", 32'(spdr_o),      32'hA5);
        check("t1_load_spcr", 32'(spcr_o),      32'h52);
        check("t1_load_ss",   32'(ss_master_o), 32'h0);
        tick(4);
        check("t1_noack_early", 32'(ack0), 32'h0);
        spif_i = 1'b1;
        tick();
        check("t1_ack0", 32'(ack0),        32'h1);
        check("t1_ack1", 32'(ack1),        32'h0);
        check("t1_rx",   32'(rx_data),     32'h3C);
        check("t1_err",  32'(err),         32'h0);
        check("t1_ss",   32'(ss_master_o), 32'h1);
        check("t1_spe",  32'(spcr_o),      32'h12);
        req0 = 1'b0; spif_i = 1'b0;
        tick();
        check("t1_ack_pulse", 32'(ack0), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);

        // Round robin from a fresh reset, both requests held, one-cycle XFER
        rst = 1'b0;
        tick(2);
        check_reset_outputs("rst2");
        rst = 1'b1;
        cfg0 = 24'h52_03_A5; cfg1 = 24'h51_07_C3; spdr_i = 8'h5A;
        spif_i = 1'b1; req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!(ack0 || ack1) && waited < 20);
            check($sformatf("t2_gnt%0d", k),   32'({ack1, ack0}), 32'(exp_g));
            check($sformatf("t2_lat%0d", k),   32'(waited),       (k == 0) ? 32'd4 : 32'd5);
            check($sformatf("t2_spibr%0d", k), 32'(spibr_o),      (k % 2 == 0) ? 32'h03 : 32'h07);
            check($sformatf("t2_rx%0d", k),    32'(rx_data),      32'h5A);
        end
        req0 = 1'b0; req1 = 1'b0; spif_i = 1'b0;
        tick();
        check("t2_idle_busy", 32'(busy), 32'h0);

        // Timeout: no spif, ack after exactly TMO XFER cycles
        spdr_i = 8'h99; req1 = 1'b1;
        tick(14);
        check("t3_noack_early", 32'(ack1), 32'h0);
        check("t3_ss_low",      32'(ss_master_o), 32'h0);
        tick();
        check("t3_ack1", 32'(ack1),        32'h1);
        check("t3_ack0", 32'(ack0),        32'h0);
        check("t3_err",  32'(err),         32'h1);
        check("t3_rx",   32'(rx_data),     32'h99);
        check("t3_ss",   32'(ss_master_o), 32'h1);
        req1 = 1'b0;
        tick();
        check("t3_idle_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of XFER
        cfg0 = 24'h52_03_A5; req0 = 1'b1;
        tick(4);
        check("t4_xfer_ss", 32'(ss_master_o), 32'h0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("t4_async");
        spif_i = 1'b1;
        tick(3);
        check_reset_outputs("t4_hold");
        rst = 1'b1;
        tick(3);
        check("t4_noack_early", 32'(ack0), 32'h0);
        tick();
        check("t4_ack0", 32'(ack0),    32'h1);
        check("t4_rx",   32'(rx_data), 32'h99);
        check("t4_err",  32'(err),     32'h0);
        req0 = 1'b0; spif_i = 1'b0;
        tick();

        // spif ignored in IDLE and CFG; spif coincident with timeout wins
        spif_i = 1'b1;
        tick();
        check("t5_idle_busy", 32'(busy), 32'h0);
        check("t5_idle_ack",  32'({ack1, ack0}), 32'h0);
        spif_i = 1'b0; spdr_i = 8'h77; req0 = 1'b1;
        tick();
        check("t5_cfg_ss", 32'(ss_master_o), 32'h1);
        spif_i = 1'b1;
        tick();
        check("t5_load_ss",   32'(ss_master_o), 32'h0);
        check("t5_load_spdr", 32'(spdr_o),      32'hA5);
        check("t5_load_ack",  32'(ack0),        32'h0);
        spif_i = 1'b0;
        tick(12);
        check("t5_noack_early", 32'(ack0), 32'h0);
        spif_i = 1'b1;
        tick();
        check("t5_ack0", 32'(ack0),    32'h1);
        check("t5_err",  32'(err),     32'h0);
        check("t5_rx",   32'(rx_data), 32'h77);
        req0 = 1'b0; spif_i = 1'b0;
        tick();

        // cfg changes after grant do not reach the core
        cfg0 = 24'h52_03_A5; req0 = 1'b1;
        tick(3);
        cfg0 = 24'hFF_FF_FF;
        tick();
        check("t6_spcr",  32'(spcr_o),  32'h52);
        check("t6_spibr", 32'(spibr_o), 32'h03);
        check("t6_spdr",  32'(spdr_o),  32'hA5);
        spif_i = 1'b1;
        tick();
        check("t6_ack0", 32'(ack0), 32'h1);
        req0 = 1'b0; spif_i = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
